slim_freeze_ctrl: RTL and testbench

Gameplay-side controller for one slime enemy. It consumes the slime sprite position and the player's ice-shot and player positions, and decides when the slime is frozen, thawed or destroyed. It drives `slim_frozen` back to the slime sprite renderer and reports hit, hurt and kill events to the game logic. All time-based behaviour advances on a one-cycle animation tick taken from the shared cycle counter.

---
 rtl/slim_freeze_ctrl.sv | 166 ++++++++++++++++
 tb/tb_slim_freeze_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slim_freeze_ctrl.sv
// Slime freeze/thaw/kill controller driven by the shared animation tick.
// Optional thaw-warning flag is built when SLIM_THAW_WARN_EN is defined.
module slim_freeze_ctrl #(
    parameter int FREEZE_TICKS = 96,
    parameter int HURT_CD      = 32,
    parameter int PLAYER_W     = 24,
    parameter int PLAYER_H     = 31,
    parameter int WARN_TICKS   = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [9:0] x_slim,
    input  logic [8:0] y_slim,
    input  logic       shot_valid,
    input  logic [9:0] shot_x,
    input  logic [8:0] shot_y,
    input  logic [9:0] player_x,
    input  logic [8:0] player_y,
    input  logic       player_push,
    input  logic       respawn,
    output logic       slim_frozen,
    output logic       slim_dead,
    output logic       shot_hit,
    output logic       player_hurt,
    output logic       slim_thaw_warn
);

    typedef enum logic [1:0] {
        WALK,
        FROZEN,
        DEAD
    } state_t;

    localparam logic [7:0] FT = 8'(FREEZE_TICKS);
    localparam logic [7:0] HC = 8'(HURT_CD);

    state_t     state;
    state_t     state_nx;
    logic [7:0] timer;
    logic [7:0] timer_nx;
    logic [7:0] cool;
    logic [7:0] cool_nx;
    logic       hit_nx;
    logic       hurt_nx;
    logic       warn_nx;

    // Widened by one bit so boxes near the screen edge never wrap.
    logic [10:0] sx_lo;
    logic [10:0] sx_hi;
    logic [10:0] shx;
    logic [10:0] px_lo;
    logic [10:0] px_hi;
    logic [9:0]  sy_lo;
    logic [9:0]  sy_hi;
    logic [9:0]  shy;
    logic [9:0]  py_lo;
    logic [9:0]  py_hi;
    logic        shot_in;
    logic        touch;

    assign sx_lo = {1'b0, x_slim};
    assign sx_hi = sx_lo + 11'd33;
    assign sy_lo = {1'b0, y_slim};
    assign sy_hi = sy_lo + 10'd32;
    assign shx   = {1'b0, shot_x};
    assign shy   = {1'b0, shot_y};
    assign px_lo = {1'b0, player_x};
    assign px_hi = px_lo + 11'(PLAYER_W);
    assign py_lo = {1'b0, player_y};
    assign py_hi = py_lo + 10'(PLAYER_H);

    assign shot_in = shot_valid
                   && (shx >= sx_lo) && (shx <= sx_hi)
                   && (shy >= sy_lo) && (shy <= sy_hi);

    assign touch = (px_lo <= sx_hi) && (px_hi >= sx_lo)
                 && (py_lo <= sy_hi) && (py_hi >= sy_lo);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        cool_nx  = cool;
        hit_nx   = 1'b0;
        hurt_nx  = 1'b0;

        if (state != DEAD && tick && cool != 8'd0) begin
            cool_nx = cool - 8'd1;
        end

        unique case (state)
            WALK: begin
                if (shot_in) begin
                    state_nx = FROZEN;
                    timer_nx = FT;
                    hit_nx   = 1'b1;
                end
                if (touch && cool == 8'd0) begin
                    hurt_nx = 1'b1;
                    cool_nx = HC;
                end
            end
            FROZEN: begin
                if (touch && player_push) begin
                    state_nx = DEAD;
                    timer_nx = 8'd0;
                end else if (shot_in) begin
                    timer_nx = FT;
                    hit_nx   = 1'b1;
                end else if (tick) begin
                    if (timer > 8'd1) begin
                        timer_nx = timer - 8'd1;
                    end else begin
                        state_nx = WALK;
                        timer_nx = 8'd0;
                    end
                end
            end
            DEAD: begin
                if (respawn) begin
                    state_nx = WALK;
                    timer_nx = 8'd0;
                    cool_nx  = 8'd0;
                end
            end
            default: begin
                state_nx = WALK;
                timer_nx = 8'd0;
            end
        endcase
    end

`ifdef SLIM_THAW_WARN_EN
    localparam logic [7:0] WT = 8'(WARN_TICKS);

    assign warn_nx = (state_nx == FROZEN) && (timer_nx <= WT);
`else
    logic unused_warn;

    assign unused_warn = ^WARN_TICKS;
    assign warn_nx     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WALK;
            timer          <= 8'd0;
            cool           <= 8'd0;
            slim_frozen    <= 1'b0;
            slim_dead      <= 1'b0;
            shot_hit       <= 1'b0;
            player_hurt    <= 1'b0;
            slim_thaw_warn <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            cool           <= cool_nx;
            slim_frozen    <= (state_nx == FROZEN);
            slim_dead      <= (state_nx == DEAD);
            shot_hit       <= hit_nx;
            player_hurt    <= hurt_nx;
            slim_thaw_warn <= warn_nx;
        end
    end

endmodule

// File: tb/tb_slim_freeze_ctrl.sv
// Directed bench for slim_freeze_ctrl: vector table plus multi-cycle
// sequences for thaw timing, hurt cooldown, kill, and async reset.
module tb_slim_freeze_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [9:0] x_slim;
    logic [8:0] y_slim;
    logic       shot_valid;
    logic [9:0] shot_x;
    logic [8:0] shot_y;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       player_push;
    logic       respawn;
    logic       slim_frozen;
    logic       slim_dead;
    logic       shot_hit;
    logic       player_hurt;
    logic       slim_thaw_warn;

    int n_tests;
    int n_fail;
    int hurt_cnt;

    slim_freeze_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .x_slim         (x_slim),
        .y_slim         (y_slim),
        .shot_valid     (shot_valid),
        .shot_x         (shot_x),
        .shot_y         (shot_y),
        .player_x       (player_x),
        .player_y       (player_y),
        .player_push    (player_push),
        .respawn        (respawn),
        .slim_frozen    (slim_frozen),
        .slim_dead      (slim_dead),
        .shot_hit       (shot_hit),
        .player_hurt    (player_hurt),
        .slim_thaw_warn (slim_thaw_warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tk;
        int xs;
        int ys;
        int sv;
        int sx;
        int sy;
        int px;
        int py;
        int pu;
        int rs;
        int fz;
        int dd;
        int ht;
        int hu;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        tick        = 1'b0;
        shot_valid  = 1'b0;
        player_push = 1'b0;
        respawn     = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic tick_gap();
        do_tick();
        for (int j = 0; j < 9; j++) step();
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic freeze(input string nm);
        shot_valid = 1'b1;
        shot_x     = 10'd333;
        shot_y     = 9'd399;
        step();
        shot_valid = 1'b0;
        chk({nm, " hit"}, int'(shot_hit), 1);
        chk({nm, " frozen"}, int'(slim_frozen), 1);
    endtask

    function automatic int warn_exp(input int tmr, input int fz);
`ifdef SLIM_THAW_WARN_EN
        return (fz == 1 && tmr <= 24) ? 1 : 0;
`else
        return (tmr < 0 && fz > 1) ? 1 : 0;
`endif
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hurt_cnt = 0;
        rst_n    = 1'b0;
        idle_in();
        x_slim   = 10'd300;
        y_slim   = 9'd367;
        shot_x   = 10'd0;
        shot_y   = 9'd0;
        player_x = 10'd0;
        player_y = 9'd0;

        //         tk xs   ys  sv sx   sy  px  py  pu rs fz dd ht hu
        tv[0]  = '{0, 300, 367, 1, 334, 399, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 300, 367, 1, 333, 400, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 300, 367, 1, 299, 367, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 300, 367, 0, 333, 399, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 300, 367, 1, 333, 399, 0, 0, 0, 0, 1, 0, 1, 0};
        tv[5]  = '{0, 300, 367, 0, 333, 399, 0, 0, 0, 0, 1, 0, 0, 0};
        tv[6]  = '{0, 300, 367, 1, 300, 367, 0, 0, 0, 0, 1, 0, 1, 0};
        tv[7]  = '{0, 300, 367, 1, 300, 367, 0, 0, 0, 0, 1, 0, 1, 0};
        tv[8]  = '{0, 300, 367, 0, 300, 367, 0, 0, 0, 0, 1, 0, 0, 0};
        tv[9]  = '{0, 300, 367, 0, 0, 0, 280, 367, 0, 0, 1, 0, 0, 0};
        tv[10] = '{0, 300, 367, 0, 0, 0, 275, 367, 1, 0, 1, 0, 0, 0};
        tv[11] = '{0, 300, 367, 0, 0, 0, 276, 336, 1, 0, 0, 1, 0, 0};
        tv[12] = '{0, 300, 367, 1, 310, 380, 276, 336, 1, 0, 0, 1, 0, 0};
        tv[13] = '{0, 300, 367, 0, 0, 0, 276, 336, 0, 1, 0, 0, 0, 0};
        tv[14] = '{0, 300, 367, 0, 0, 0, 276, 336, 0, 0, 0, 0, 0, 1};
        tv[15] = '{0, 300, 367, 0, 0, 0, 276, 336, 0, 0, 0, 0, 0, 0};
        tv[16] = '{0, 1000, 490, 1, 1023, 511, 0, 0, 0, 0, 1, 0, 1, 0};
        tv[17] = '{0, 1000, 490, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

        #1;
        chk("reset frozen", int'(slim_frozen), 0);
        chk("reset dead", int'(slim_dead), 0);
        chk("reset hit", int'(shot_hit), 0);
        chk("reset hurt", int'(player_hurt), 0);
        chk("reset warn", int'(slim_thaw_warn), 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            tick        = tv[i].tk[0];
            x_slim      = tv[i].xs[9:0];
            y_slim      = tv[i].ys[8:0];
            shot_valid  = tv[i].sv[0];
            shot_x      = tv[i].sx[9:0];
            shot_y      = tv[i].sy[8:0];
            player_x    = tv[i].px[9:0];
            player_y    = tv[i].py[8:0];
            player_push = tv[i].pu[0];
            respawn     = tv[i].rs[0];
            step();
            chk($sformatf("vec%0d frozen", i), int'(slim_frozen), tv[i].fz);
            chk($sformatf("vec%0d dead", i), int'(slim_dead), tv[i].dd);
            chk($sformatf("vec%0d hit", i), int'(shot_hit), tv[i].ht);
            chk($sformatf("vec%0d hurt", i), int'(player_hurt), tv[i].hu);
            chk($sformatf("vec%0d warn", i), int'(slim_thaw_warn), 0);
        end

        // Thaw timing: full 96-tick freeze.
        idle_in();
        x_slim   = 10'd300;
        y_slim   = 9'd367;
        player_x = 10'd0;
        player_y = 9'd0;
        do_reset();
        freeze("thaw");
        for (int k = 1; k <= 96; k++) begin
            tick_gap();
            chk($sformatf("thaw t%0d frozen", k), int'(slim_frozen),
                (k < 96) ? 1 : 0);
            chk($sformatf("thaw t%0d warn", k), int'(slim_thaw_warn),
                warn_exp(96 - k, (k < 96) ? 1 : 0));
        end

        // Re-hit at tick 50 restarts the 96-tick window.
        freeze("rehit0");
        for (int k = 1; k <= 50; k++) tick_gap();
        chk("rehit t50 frozen", int'(slim_frozen), 1);
        freeze("rehit");
        for (int k = 1; k <= 96; k++) begin
            tick_gap();
            chk($sformatf("rehit t%0d frozen", k), int'(slim_frozen),
                (k < 96) ? 1 : 0);
            chk($sformatf("rehit t%0d warn", k), int'(slim_thaw_warn),
                warn_exp(96 - k, (k < 96) ? 1 : 0));
        end

        // Hurt cooldown with the player held overlapping.
        do_reset();
        player_x = 10'd280;
        player_y = 9'd367;
        step();
        chk("hurt entry", int'(player_hurt), 1);
        for (int k = 1; k <= 32; k++) begin
            do_tick();
            chk($sformatf("hurt cd t%0d", k), int'(player_hurt), 0);
            if (k < 32) begin
                step();
                chk($sformatf("hurt cd idle%0d", k), int'(player_hurt), 0);
            end
        end
        step();
        chk("hurt after cd", int'(player_hurt), 1);
        step();
        chk("hurt single pulse", int'(player_hurt), 0);
        freeze("hurtfrz");
        chk("hurt on freeze", int'(player_hurt), 0);
        for (int k = 1; k <= 40; k++) begin
            do_tick();
            hurt_cnt += int'(player_hurt);
            for (int j = 0; j < 3; j++) begin
                step();
                hurt_cnt += int'(player_hurt);
            end
        end
        chk("hurt while frozen", hurt_cnt, 0);
        chk("frozen after 40", int'(slim_frozen), 1);

        // Kill on the last thaw tick, then ignored shot and respawn.
        player_x = 10'd0;
        player_y = 9'd0;
        do_reset();
        freeze("kill");
        for (int k = 1; k <= 95; k++) tick_gap();
        chk("kill pre frozen", int'(slim_frozen), 1);
        tick        = 1'b1;
        player_push = 1'b1;
        player_x    = 10'd280;
        player_y    = 9'd367;
        step();
        idle_in();
        chk("kill dead", int'(slim_dead), 1);
        chk("kill frozen", int'(slim_frozen), 0);
        chk("kill hit", int'(shot_hit), 0);
        shot_valid = 1'b1;
        shot_x     = 10'd333;
        shot_y     = 9'd399;
        step();
        shot_valid = 1'b0;
        chk("dead shot hit", int'(shot_hit), 0);
        chk("dead shot frozen", int'(slim_frozen), 0);
        chk("dead stays", int'(slim_dead), 1);
        chk("dead no hurt", int'(player_hurt), 0);
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        chk("respawn dead", int'(slim_dead), 0);
        chk("respawn frozen", int'(slim_frozen), 0);
        chk("respawn hurt", int'(player_hurt), 0);
        step();
        chk("respawn cd zero", int'(player_hurt), 1);
        do_tick();
        chk("respawn tick frozen", int'(slim_frozen), 0);

        // Async reset in the middle of a freeze (timer = 40).
        player_x = 10'd0;
        player_y = 9'd0;
        do_reset();
        freeze("rst");
        for (int k = 1; k <= 56; k++) tick_gap();
        chk("rst pre frozen", int'(slim_frozen), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst async frozen", int'(slim_frozen), 0);
        chk("rst async dead", int'(slim_dead), 0);
        chk("rst async hit", int'(shot_hit), 0);
        chk("rst async hurt", int'(player_hurt), 0);
        chk("rst async warn", int'(slim_thaw_warn), 0);
        #2;
        rst_n = 1'b1;
        step();
        chk("rst idle frozen", int'(slim_frozen), 0);
        do_tick();
        chk("rst tick frozen", int'(slim_frozen), 0);
        chk("rst tick hit", int'(shot_hit), 0);
        chk("rst tick warn", int'(slim_thaw_warn), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
